data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter sharing the single scalar data-memory port between the scalar pipeline (requester 0) and the vector unit (requester 1, vector ops with V=1). It sits between both load/store paths and the data memory, grants at most one access per cycle, and routes synchronous-read data back to the issuer one cycle later. Fairness is round-robin, with an optional bounded lock so the vector unit can stream bursts.

## Interface
- N, 24, data and address width (matches processor word)
- MAX_BURST, 4, max consecutive grants one locked requester may hold while the other waits (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  2  access request per requester; bit i = requester i
- we  in  2  write enable per requester (1 = store, 0 = load)
- lock  in  2  request to keep ownership on the next cycle
- addr0 / addr1  in  N  access address, requester 0 / 1
- wdata0 / wdata1  in  N  store data, requester 0 / 1
- gnt  out  2  one-hot or zero; combinational grant this cycle
- rvalid  out  2  load data valid for requester i (registered)
- rdata0 / rdata1  out  N  load data, requester 0 / 1
- mem_we  out  1  to data memory ScalarMemWrite
- mem_addr  out  N  to data memory A
- mem_wdata  out  N  to data memory WD
- mem_rdata  in  N  data memory RD; valid one cycle after a read address

## Operation
- FSM, states IDLE, OWN0, OWN1: owner = last requester granted. Plus priority pointer prio (1 bit) and burst_cnt (width clog2(MAX_BURST+1)).
- Winner selection each cycle:
  - No req: no grant; state → IDLE; burst_cnt and prio hold.
  - One req: that requester wins.
  - Both req, state OWNi with lock_i=1 registered from its last grant and burst_cnt < MAX_BURST: i wins.
  - Otherwise both req: prio wins.
- On grant to i: prio ← ~i; state → OWNi; burst_cnt ← burst_cnt+1 if previous state was OWNi, else 1. Saturate at MAX_BURST.
- lock_i is sampled at the cycle of grant to i; stored as lock_held.
- Memory side: on grant, mem_addr/mem_wdata/mem_we = winner's addr/wdata/we. No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return: a granted load sets rd_pend[i] for one cycle. Next cycle rvalid[i]=1 and rdata_i = mem_rdata. Otherwise rdata_i = 0.
- A store never produces rvalid.
- Requester must hold req/we/addr/wdata until it sees gnt. Dropping req before gnt is legal and withdraws the access.

## Timing
- Grant latency: 0 cycles, same cycle as req. Read data latency: 1 cycle after gnt.
- Throughput: one access per cycle. Back-to-back loads from different requesters give rvalid to each on consecutive cycles.
- Reset (asynchronous, rst=0):
  - State: IDLE, prio=0, burst_cnt=0, lock_held=0, rd_pend=0.
  - Outputs: gnt=0, rvalid=0, rdata*=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset while a read is pending: the pending rvalid is discarded and never asserted.
- Starvation bound: a waiting requester is granted within MAX_BURST+1 cycles.
- Simultaneous lock release and new request on the same edge: lock_held reflects only the lock value sampled at the grant.
- Lock honoured by an uncontended requester does not reset when the other is idle; burst_cnt keeps counting but only limits when contention exists.

## Structure
- Package dmem_arb_pkg:
  - typedef enum state_t {IDLE, OWN0, OWN1}
  - localparam REQ_SCALAR=0, REQ_VECTOR=1
- One sub-module, rr_pick: combinational 2-way winner logic.
  - Inputs: req, prio, owner, lock_held, burst_ok.
  - Output: one-hot grant.
- Top holds the FSM, counters, the memory mux and the read-return registers.

## Test plan
- Single scalar load: req=01, we=00, addr0=0x10, mem_rdata=0xABCDEF next cycle → gnt=01 same cycle; rvalid=01 and rdata0=0xABCDEF the following cycle.
- Tie, no lock: req=11 held four cycles from reset → gnt sequence 01,10,01,10.
- Locked vector burst: MAX_BURST=4, req=11, lock=10, vector granted first → gnt=10 four times, then 01, then 10.
- Store: req=10, we=10, addr1=0x20, wdata1=0x123456 → mem_we=1, mem_addr=0x20, mem_wdata=0x123456 that cycle; rvalid stays 00.
- Async reset mid-read: grant a load to requester 1, assert rst low before the next edge → rvalid never asserts; all outputs 0; first grant after release with req=11 goes to requester 0.
- Idle gap: req=00 for 2 cycles between accesses → gnt=00, mem_we=0, mem_addr=0; prio unchanged across the gap.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the scalar/vector data-memory arbiter.
package dmem_arb_pkg;

   // Owner of the memory port: none since the last idle cycle, scalar, or vector.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam int REQ_SCALAR = 0;
   localparam int REQ_VECTOR = 1;

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// Two-way winner selection: a lone requester always wins, a locked owner
// keeps the port while its burst budget lasts, otherwise the priority pointer decides.
module rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   input  state_t     owner,
   input  logic       lock_held,
   input  logic       burst_ok,
   output logic [1:0] gnt
);

   // One-hot (or zero) grant for this cycle
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01: gnt[REQ_SCALAR] = 1'b1;
         2'b10: gnt[REQ_VECTOR] = 1'b1;
         2'b11: begin
            if (lock_held && burst_ok && (owner == OWN0)) begin
               gnt[REQ_SCALAR] = 1'b1;
            end else if (lock_held && burst_ok && (owner == OWN1)) begin
               gnt[REQ_VECTOR] = 1'b1;
            end else if (prio) begin
               gnt[REQ_VECTOR] = 1'b1;
            end else begin
               gnt[REQ_SCALAR] = 1'b1;
            end
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one synchronous-read data-memory port between the scalar
// pipeline (requester 0) and the vector unit (requester 1).
//
//   state | meaning
//   IDLE  | no grant last cycle; lock has no effect
//   OWN0  | scalar pipeline was granted last cycle
//   OWN1  | vector unit was granted last cycle
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int N         = 24,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req,
   input  logic [1:0]   we,
   input  logic [1:0]   lock,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] addr1,
   input  logic [N-1:0] wdata0,
   input  logic [N-1:0] wdata1,
   output logic [1:0]   gnt,
   output logic [1:0]   rvalid,
   output logic [N-1:0] rdata0,
   output logic [N-1:0] rdata1,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
);

   localparam int            CW        = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   state_t        state_q, state_d;
   logic          prio_q, prio_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic          lock_held_q, lock_held_d;
   logic [1:0]    rd_pend_q, rd_pend_d;
   logic [1:0]    pick;
   logic          burst_ok;
   logic [CW-1:0] burst_inc;

   assign burst_ok  = (burst_cnt_q < BURST_MAX);
   assign burst_inc = burst_ok ? (burst_cnt_q + CW'(1)) : burst_cnt_q;

   rr_pick u_rr_pick (
      .req       (req),
      .prio      (prio_q),
      .owner     (state_q),
      .lock_held (lock_held_q),
      .burst_ok  (burst_ok),
      .gnt       (pick)
   );

   // Grant is forced off while reset is held so nothing reaches memory
   always_comb begin
      gnt = 2'b00;
      if (rst) begin
         gnt = pick;
      end
   end

   // Next owner, priority pointer, burst count, lock capture and read tracking
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      burst_cnt_d = burst_cnt_q;
      lock_held_d = lock_held_q;
      rd_pend_d   = 2'b00;
      if (gnt[REQ_SCALAR]) begin
         state_d               = OWN0;
         prio_d                = 1'b1;
         lock_held_d           = lock[REQ_SCALAR];
         burst_cnt_d           = (state_q == OWN0) ? burst_inc : CW'(1);
         rd_pend_d[REQ_SCALAR] = ~we[REQ_SCALAR];
      end else if (gnt[REQ_VECTOR]) begin
         state_d               = OWN1;
         prio_d                = 1'b0;
         lock_held_d           = lock[REQ_VECTOR];
         burst_cnt_d           = (state_q == OWN1) ? burst_inc : CW'(1);
         rd_pend_d[REQ_VECTOR] = ~we[REQ_VECTOR];
      end else begin
         state_d = IDLE;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         burst_cnt_q <= '0;
         lock_held_q <= 1'b0;
         rd_pend_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         burst_cnt_q <= burst_cnt_d;
         lock_held_q <= lock_held_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   // Memory port mux: winner's access, or all zero when nobody is granted
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt[REQ_SCALAR]) begin
         mem_we    = we[REQ_SCALAR];
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (gnt[REQ_VECTOR]) begin
         mem_we    = we[REQ_VECTOR];
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   // Read return: memory data steered to whichever requester issued the load
   always_comb begin
      rvalid = rd_pend_q;
      rdata0 = rd_pend_q[REQ_SCALAR] ? mem_rdata : '0;
      rdata1 = rd_pend_q[REQ_VECTOR] ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed-vector bench for the data-memory arbiter.
module tb_data_mem_arbiter;

   localparam int N = 24;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req, we, lock;
   logic [N-1:0] addr0, addr1, wdata0, wdata1, mem_rdata;
   logic [1:0]   gnt, rvalid;
   logic [N-1:0] rdata0, rdata1, mem_addr, mem_wdata;
   logic         mem_we;

   int total = 0;
   int bad   = 0;

   data_mem_arbiter #(.N(N), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .lock      (lock),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
      #1 rst = 1'b0;
      #2;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
      total++; if (rdata0 !== 24'h0 || rdata1 !== 24'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
      total++; if (mem_we !== 1'b0 || mem_addr !== 24'h0 || mem_wdata !== 24'h0) begin
         bad++; $display("FAIL reset_mem got we=%b a=%h d=%h exp 0", mem_we, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_tie_no_lock();
      logic [1:0] exp_seq [4];
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      req = 2'b11; we = 2'b00; lock = 2'b00;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (gnt !== exp_seq[i]) begin bad++; $display("FAIL tie_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]); end
         tick();
      end
      req = 2'b00;
      #1 tick();
   endtask

   task automatic test_scalar_load();
      req = 2'b01; we = 2'b00; addr0 = 24'h000010;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL load_gnt got=%b exp=01", gnt); end
      total++; if (mem_addr !== 24'h000010 || mem_we !== 1'b0) begin
         bad++; $display("FAIL load_mem got a=%h we=%b exp a=000010 we=0", mem_addr, mem_we);
      end
      tick();
      req = 2'b00; mem_rdata = 24'hABCDEF;
      #1;
      total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL load_rvalid got=%b exp=01", rvalid); end
      total++; if (rdata0 !== 24'hABCDEF) begin bad++; $display("FAIL load_rdata0 got=%h exp=abcdef", rdata0); end
      total++; if (rdata1 !== 24'h0) begin bad++; $display("FAIL load_rdata1 got=%h exp=000000", rdata1); end
      tick();
      total++; if (rvalid !== 2'b00 || rdata0 !== 24'h0) begin
         bad++; $display("FAIL load_after got rvalid=%b rdata0=%h exp 00/000000", rvalid, rdata0);
      end
      mem_rdata = '0;
   endtask

   task automatic test_idle_gap();
      // prio is 1 here (last grant went to requester 0)
      addr0 = 24'h000033; addr1 = 24'h000044; wdata0 = 24'h777777; we = 2'b11;
      req = 2'b00;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (gnt !== 2'b00 || mem_we !== 1'b0 || mem_addr !== 24'h0 || mem_wdata !== 24'h0) begin
            bad++; $display("FAIL gap[%0d] got gnt=%b we=%b a=%h d=%h exp 00/0/0/0", i, gnt, mem_we, mem_addr, mem_wdata);
         end
         tick();
      end
      we = 2'b00; req = 2'b11;
      #1;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL gap_prio got=%b exp=10", gnt); end
      tick();
      req = 2'b00;
      #1 tick();
   endtask

   task automatic test_store();
      req = 2'b10; we = 2'b10; addr1 = 24'h000020; wdata1 = 24'h123456;
      #1;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL store_gnt got=%b exp=10", gnt); end
      total++; if (mem_we !== 1'b1 || mem_addr !== 24'h000020 || mem_wdata !== 24'h123456) begin
         bad++; $display("FAIL store_mem got we=%b a=%h d=%h exp 1/000020/123456", mem_we, mem_addr, mem_wdata);
      end
      tick();
      req = 2'b00; we = 2'b00; mem_rdata = 24'h555555;
      #1;
      total++; if (rvalid !== 2'b00 || rdata1 !== 24'h0) begin
         bad++; $display("FAIL store_rvalid got=%b rdata1=%h exp 00/000000", rvalid, rdata1);
      end
      mem_rdata = '0;
      tick();
   endtask

   task automatic test_locked_burst();
      logic [1:0] exp_seq [6];
      exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
      // A lone scalar access moves the pointer to the vector unit
      req = 2'b01; we = 2'b00; lock = 2'b00;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL burst_pre got=%b exp=01", gnt); end
      tick();
      req = 2'b11; lock = 2'b10;
      for (int i = 0; i < 6; i++) begin
         #1;
         total++; if (gnt !== exp_seq[i]) begin bad++; $display("FAIL burst_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]); end
         tick();
      end
      req = 2'b00; lock = 2'b00;
      #1 tick();
   endtask

   task automatic test_back_to_back();
      // Idle beforehand so prio=0 decides the tie
      req = 2'b11; we = 2'b00; lock = 2'b00; addr0 = 24'h000100; addr1 = 24'h000200;
      #1;
      total++; if (gnt !== 2'b01 || mem_addr !== 24'h000100) begin
         bad++; $display("FAIL b2b_first got gnt=%b a=%h exp 01/000100", gnt, mem_addr);
      end
      tick();
      req = 2'b10; mem_rdata = 24'h111111;
      #1;
      total++; if (gnt !== 2'b10 || mem_addr !== 24'h000200) begin
         bad++; $display("FAIL b2b_second got gnt=%b a=%h exp 10/000200", gnt, mem_addr);
      end
      total++; if (rvalid !== 2'b01 || rdata0 !== 24'h111111) begin
         bad++; $display("FAIL b2b_rv0 got rvalid=%b rdata0=%h exp 01/111111", rvalid, rdata0);
      end
      tick();
      req = 2'b00; mem_rdata = 24'h222222;
      #1;
      total++; if (rvalid !== 2'b10 || rdata1 !== 24'h222222 || rdata0 !== 24'h0) begin
         bad++; $display("FAIL b2b_rv1 got rvalid=%b rdata1=%h rdata0=%h exp 10/222222/000000", rvalid, rdata1, rdata0);
      end
      tick();
      mem_rdata = '0;
   endtask

   task automatic test_reset_mid_read();
      req = 2'b10; we = 2'b00; addr1 = 24'h000300; mem_rdata = 24'h0F0F0F;
      #1;
      total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rst_mid_gnt got=%b exp=10", gnt); end
      #1 rst = 1'b0;
      #1;
      total++; if (gnt !== 2'b00 || mem_addr !== 24'h0 || rvalid !== 2'b00) begin
         bad++; $display("FAIL rst_mid_outs got gnt=%b a=%h rvalid=%b exp 00/0/00", gnt, mem_addr, rvalid);
      end
      tick();
      total++; if (rvalid !== 2'b00 || rdata1 !== 24'h0) begin
         bad++; $display("FAIL rst_mid_rvalid got=%b rdata1=%h exp 00/000000", rvalid, rdata1);
      end
      req = 2'b11;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rst_release_gnt got=%b exp=01", gnt); end
      tick();
      req = 2'b00;
      #1;
      total++; if (rvalid !== 2'b01 || rdata0 !== 24'h0F0F0F) begin
         bad++; $display("FAIL rst_release_rv got rvalid=%b rdata0=%h exp 01/0f0f0f", rvalid, rdata0);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_tie_no_lock();
      test_scalar_load();
      test_idle_gap();
      test_store();
      test_locked_burst();
      test_back_to_back();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
